alu_dispatch: RTL and testbench

ALU_DISPATCH -- requirements
Module: alu_dispatch

---
 rtl/alu_dispatch.sv | 117 +++++++++++
 tb/tb_alu_dispatch.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_dispatch.sv
// alu_dispatch: queues ALU commands in a FIFO and issues them one at a time to four units, holding each result until consumed.
// Define ALU_DISPATCH_LEVEL_EN to expose the registered FIFO occupancy on cmd_level.
module alu_dispatch #(
  parameter int width = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [width-1:0] cmd_A,
  input  logic [width-1:0] cmd_B,
  input  logic [3:0]       cmd_FUN,
  output logic [width-1:0] A_out,
  output logic [width-1:0] B_out,
  output logic [1:0]       FUN_out,
  output logic             Arith_Enable,
  output logic             Logic_Enable,
  output logic             CMP_Enable,
  output logic             Shift_Enable,
  input  logic [width-1:0] Arith_OUT,
  input  logic [width-1:0] Logic_OUT,
  input  logic [width-1:0] CMP_OUT,
  input  logic [width-1:0] Shift_OUT,
  input  logic             Arith_Flag,
  input  logic             Logic_Flag,
  input  logic             CMP_Flag,
  input  logic             Shift_Flag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [width-1:0] res_data,
  output logic             res_err
`ifdef ALU_DISPATCH_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] cmd_level
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
  state_t state_q, state_d;
  logic [width-1:0] a_mem [DEPTH];
  logic [width-1:0] b_mem [DEPTH];
  logic [3:0] f_mem [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] cnt_q, cnt_d;
  logic [1:0] sel_q, sel_d;
  logic [width-1:0] data_q, data_d;
  logic err_q, err_d;
  logic push, issue;
  logic [3:0] head_f, flags;
  assign cmd_ready = cnt_q != FULL;
  assign flags = {Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag};
`ifdef ALU_DISPATCH_LEVEL_EN
  assign cmd_level = cnt_q;
`endif
  always_comb begin
    head_f = f_mem[rd_q];
    issue = state_q == ISSUE;
    push = cmd_valid && cmd_ready;
    wr_d = wr_q + PW'(push);
    rd_d = rd_q + PW'(issue);
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(issue);
    sel_d = issue ? head_f[3:2] : sel_q;
    data_d = state_q != WAIT ? data_q :
             sel_q == 2'd0 ? Arith_OUT :
             sel_q == 2'd1 ? Logic_OUT :
             sel_q == 2'd2 ? CMP_OUT : Shift_OUT;
    err_d = state_q == WAIT ? ~flags[sel_q] : err_q;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = cnt_q != '0 ? ISSUE : IDLE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = HOLD;
      default: state_d = !res_ready ? HOLD : cnt_q != '0 ? ISSUE : IDLE;
    endcase
  end
  always_comb begin
    A_out = issue ? a_mem[rd_q] : '0;
    B_out = issue ? b_mem[rd_q] : '0;
    FUN_out = issue ? head_f[1:0] : 2'b0;
    Arith_Enable = issue && head_f[3:2] == 2'd0;
    Logic_Enable = issue && head_f[3:2] == 2'd1;
    CMP_Enable = issue && head_f[3:2] == 2'd2;
    Shift_Enable = issue && head_f[3:2] == 2'd3;
    res_valid = state_q == HOLD;
    res_data = data_q;
    res_err = err_q;
  end
  // Storage carries no reset: emptiness is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      a_mem[wr_q] <= cmd_A;
      b_mem[wr_q] <= cmd_B;
      f_mem[wr_q] <= cmd_FUN;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      sel_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      data_q <= data_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_alu_dispatch.sv
// tb_alu_dispatch: table vectors, timing sequences and random traffic against a queue-based model of alu_dispatch.
module tb_alu_dispatch;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  logic cmd_valid = 0, cmd_ready, res_ready = 0, res_valid, res_err;
  logic [15:0] cmd_A = 0, cmd_B = 0, A_out, B_out, res_data;
  logic [3:0] cmd_FUN = 0, en, u_flag;
  logic [1:0] FUN_out;
  logic Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable;
  logic [15:0] u_out [4];
`ifdef ALU_DISPATCH_LEVEL_EN
  logic [2:0] cmd_level;
`endif
  assign en = {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable};
  alu_dispatch #(.width(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_A(cmd_A), .cmd_B(cmd_B), .cmd_FUN(cmd_FUN),
    .A_out(A_out), .B_out(B_out), .FUN_out(FUN_out),
    .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable), .CMP_Enable(CMP_Enable), .Shift_Enable(Shift_Enable),
    .Arith_OUT(u_out[0]), .Logic_OUT(u_out[1]), .CMP_OUT(u_out[2]), .Shift_OUT(u_out[3]),
    .Arith_Flag(u_flag[0]), .Logic_Flag(u_flag[1]), .CMP_Flag(u_flag[2]), .Shift_Flag(u_flag[3]),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
`ifdef ALU_DISPATCH_LEVEL_EN
    , .cmd_level(cmd_level)
`endif
  );
  typedef struct packed { logic [3:0] fun; logic [15:0] a, b; } cmd_t;
  typedef struct { logic [3:0] fun; logic [15:0] a, b; logic [3:0] en; logic [1:0] fo; logic [15:0] d; logic e; } vec_t;
  cmd_t issue_q[$];
  logic [16:0] res_q[$];
  int vecs = 0, errs = 0;
  // Behaviour of the external units: {err, result}; an operand A ending in 0xF makes the unit drop its flag.
  function automatic logic [16:0] unit_fn(logic [3:0] f, logic [15:0] a, logic [15:0] b);
    logic [15:0] r;
    logic [3:0] s;
    s = b[3:0];
    if (a[3:0] == 4'hF) return 17'h10000;
    case (f[3:2])
      2'd0: r = f[1:0] == 0 ? a + b : f[1:0] == 1 ? a - b : f[1:0] == 2 ? a + 16'd1 : b - a;
      2'd1: r = f[1:0] == 0 ? a & b : f[1:0] == 1 ? a | b : f[1:0] == 2 ? a ^ b : ~a;
      2'd2: r = {15'd0, f[1:0] == 0 ? a == b : f[1:0] == 1 ? a < b : f[1:0] == 2 ? a > b : a != b};
      default: r = f[1:0] == 0 ? a << s : f[1:0] == 1 ? a >> s : f[1:0] == 2 ? 16'(({a, a} << s) >> 16) : 16'($signed(a) >>> s);
    endcase
    return {1'b0, r};
  endfunction
  // Units answer one cycle after their enable; idle units present noise.
  initial begin
    u_out = '{default: 16'h0};
    u_flag = 4'h0;
    forever begin
      logic [3:0] e;
      logic [15:0] a, b;
      logic [1:0] op;
      logic [16:0] r;
      @(posedge clk);
      e = en; a = A_out; b = B_out; op = FUN_out;
      #1;
      for (int u = 0; u < 4; u++) begin
        r = unit_fn({2'(u), op}, a, b);
        u_out[u] = e[u] ? r[15:0] : 16'($urandom);
        u_flag[u] = e[u] ? ~r[16] : 1'($urandom);
      end
    end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input logic v, input cmd_t c, input logic rr, output logic acc);
    cmd_t h;
    logic [16:0] r;
    @(negedge clk);
    cmd_valid = v; cmd_A = c.a; cmd_B = c.b; cmd_FUN = c.fun; res_ready = rr;
`ifdef ALU_DISPATCH_LEVEL_EN
    chk("level", cmd_level, issue_q.size());
`endif
    if (en != 0) begin
      chk("issue_onehot", $countones(en), 1);
      chk("issue_res_valid", res_valid, 0);
      if (issue_q.size() == 0) chk("spurious_issue", en, 0);
      else begin
        h = issue_q.pop_front();
        chk("issue_unit", en, 4'b1 << h.fun[3:2]);
        chk("issue_ops", {A_out, B_out, FUN_out}, {h.a, h.b, h.fun[1:0]});
      end
    end else chk("idle_outs", {A_out, B_out, FUN_out}, 0);
    if (res_valid && rr) begin
      if (res_q.size() == 0) chk("spurious_result", res_valid, 0);
      else begin
        r = res_q.pop_front();
        chk("result", {res_err, res_data}, r);
      end
    end
    acc = v && cmd_ready;
    if (acc) begin
      issue_q.push_back(c);
      res_q.push_back(unit_fn(c.fun, c.a, c.b));
    end
  endtask
  task automatic drain(input string name);
    logic acc;
    for (int i = 0; i < 60 && res_q.size() != 0; i++) step(0, '0, 1, acc);
    step(0, '0, 0, acc);
    chk(name, {res_q.size(), issue_q.size(), res_valid}, 0);
  endtask
  vec_t tbl[7];
  initial begin
    logic acc;
    cmd_t c;
    int n;
    tbl[0] = '{4'b0100, 16'h00F0, 16'h0FF0, 4'b0010, 2'b00, 16'h00F0, 1'b0};
    tbl[1] = '{4'b0000, 16'h1234, 16'h1111, 4'b0001, 2'b00, 16'h2345, 1'b0};
    tbl[2] = '{4'b1001, 16'h0003, 16'h0005, 4'b0100, 2'b01, 16'h0001, 1'b0};
    tbl[3] = '{4'b1110, 16'h0081, 16'h0004, 4'b1000, 2'b10, 16'h0810, 1'b0};
    tbl[4] = '{4'b0101, 16'h000F, 16'hFFFF, 4'b0010, 2'b01, 16'h0000, 1'b1};
    tbl[5] = '{4'b1111, 16'h8000, 16'h0004, 4'b1000, 2'b11, 16'hF800, 1'b0};
    tbl[6] = '{4'b0001, 16'h0005, 16'h0007, 4'b0001, 2'b01, 16'hFFFE, 1'b0};
    @(negedge clk);
    chk("reset_outs", {A_out, B_out, FUN_out, en, res_valid, res_data, res_err}, 0);
    chk("reset_ready", cmd_ready, 1);
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 7; i++) begin
      step(1, '{tbl[i].fun, tbl[i].a, tbl[i].b}, 0, acc);
      chk("tbl_ready", cmd_ready, 1);
      step(0, '0, 0, acc);
      chk("tbl_e0_quiet", {en, res_valid}, 0);
      step(0, '0, 0, acc);
      chk("tbl_e1_enable", en, tbl[i].en);
      chk("tbl_e1_ops", {A_out, B_out, FUN_out}, {tbl[i].a, tbl[i].b, tbl[i].fo});
      step(0, '0, 0, acc);
      chk("tbl_e2_wait", {en, res_valid}, 0);
      step(0, '0, 0, acc);
      chk("tbl_e3_result", {res_valid, res_err, res_data}, {1'b1, tbl[i].e, tbl[i].d});
      step(0, '0, 1, acc);
      step(0, '0, 0, acc);
      chk("tbl_released", res_valid, 0);
    end
    n = 0;
    for (int i = 0; i < 20 && n < 5; i++) begin
      step(1, '{4'(n * 5), 16'(n * 16'h1111), 16'(n + 1)}, 0, acc);
      if (acc) n++;
    end
    chk("fill_accepted", n, 5);
    for (int i = 0; i < 4; i++) begin
      step(1, '{4'h0, 16'hDEAD, 16'hBEEF}, 0, acc);
      chk("fill_full", {cmd_ready, res_valid}, 2'b01);
    end
    drain("fill_drain");
    for (int k = 0; k < 14; k++) begin
      step(k < 3, '{4'(k * 6), 16'(k + 100), 16'(k + 3)}, 1, acc);
      chk("b2b_issue", en != 0, k inside {2, 5, 8});
      chk("b2b_hold", res_valid, k inside {4, 7, 10});
    end
    drain("b2b_drain");
    for (int k = 0; k < 3; k++) step(1, '{4'(k * 4), 16'h0100, 16'h0001}, 0, acc);
    step(0, '0, 0, acc);
    chk("mid_wait", {en, res_valid}, 0);
    rst = 0;
    #1;
    chk("mid_reset_outs", {A_out, B_out, FUN_out, en, res_valid, res_data, res_err}, 0);
    chk("mid_reset_ready", cmd_ready, 1);
    issue_q.delete();
    res_q.delete();
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 8; i++) begin
      step(0, '0, 1, acc);
      chk("post_reset_quiet", {en, res_valid, cmd_ready}, 1);
    end
    for (int i = 0; i < 400; i++) begin
      c = '{4'($urandom), 16'($urandom), 16'($urandom)};
      step($urandom_range(0, 9) < 6, c, $urandom_range(0, 9) < 7, acc);
    end
    drain("random_drain");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
